shift_right_iter: RTL and testbench

SHIFT_RIGHT_ITER -- requirements
Module: shift_right_iter

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_right_step.sv | 26 ++
 rtl/shift_right_iter.sv | 118 +++++++++++
 tb/tb_shift_right_iter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative right shifter.
//
// Holds the controller state encoding and the number of bit positions
// moved per SHIFT cycle.
//
// Build option:
//   SHIFT_RIGHT_FAST_EN  defined   -> STEP = 4 (up to four positions per cycle)
//                        undefined -> STEP = 1 (one position per cycle)
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

`ifdef SHIFT_RIGHT_FAST_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 1;
`endif

endpackage

// File: rtl/shift_right_step.sv
// One combinational shift step of the iterative right shifter.
//
// Ports:
//   acc_i   current accumulator value
//   s_i     number of positions to shift this step
//   fill_i  1 = replicate acc_i MSB into vacated positions, 0 = zero fill
//   acc_o   shifted accumulator
module shift_right_step #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [SHW-1:0]   s_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] acc_o
);

  logic             fill_bit;
  logic [WIDTH-1:0] fill_mask;

  // Mask covers exactly the s_i vacated upper positions.
  assign fill_bit  = fill_i & acc_i[WIDTH-1];
  assign fill_mask = ~({WIDTH{1'b1}} >> s_i);
  assign acc_o     = (acc_i >> s_i) | ({WIDTH{fill_bit}} & fill_mask);

endmodule

// File: rtl/shift_right_iter.sv
// Iterative logical/arithmetic right shifter.
//
// A start in IDLE captures A, bits and arith; the accumulator is then shifted
// by up to STEP positions per cycle until the remaining count is zero. The
// result is registered on entry to DONE, where done pulses for one cycle.
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   start    request, sampled only in IDLE
//   A        operand
//   bits     shift amount (log2(WIDTH) bits)
//   arith    1 = arithmetic (sign fill), 0 = logical (zero fill)
//   busy     high whenever not IDLE
//   done     high in the DONE cycle only
//   A_shift  registered result, held until the next completion or reset
//
// Build option: SHIFT_RIGHT_FAST_EN selects STEP = 4 (see shift_pkg).
module shift_right_iter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         A,
  input  logic [$clog2(WIDTH)-1:0] bits,
  input  logic                     arith,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         A_shift
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] STEP_V = SHW'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] a_shift_q, a_shift_d;

  logic [SHW-1:0]   step_s;
  logic [WIDTH-1:0] step_acc;

  // Shift by STEP until fewer than STEP positions remain.
  assign step_s = (cnt_q > STEP_V) ? STEP_V : cnt_q;

  shift_right_step #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_step (
    .acc_i  (acc_q),
    .s_i    (step_s),
    .fill_i (fill_q),
    .acc_o  (step_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      fill_q    <= 1'b0;
      a_shift_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      a_shift_q <= a_shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    a_shift_d = a_shift_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d  = A;
          cnt_d  = bits;
          fill_d = arith;
          if (bits == '0) begin
            // Zero shift: result is the operand itself, skip SHIFT.
            state_d   = DONE;
            a_shift_d = A;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_d = step_acc;
        cnt_d = cnt_q - step_s;
        if (cnt_d == '0) begin
          state_d   = DONE;
          a_shift_d = step_acc;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign A_shift = a_shift_q;

endmodule

// File: tb/tb_shift_right_iter.sv
module tb_shift_right_iter;

`ifdef SHIFT_RIGHT_FAST_EN
  localparam int STEP_TB = 4;
`else
  localparam int STEP_TB = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [4:0]  bits;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] A_shift;

  int n_tests = 0;
  int n_fail  = 0;

  shift_right_iter #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (A),
    .bits    (bits),
    .arith   (arith),
    .busy    (busy),
    .done    (done),
    .A_shift (A_shift)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  b;
    logic        ar;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] ref_shift(logic [31:0] a, logic [4:0] b, logic ar);
    if (ar) return 32'($signed(a) >>> b);
    return a >> b;
  endfunction

  function automatic int ref_lat(logic [4:0] b);
    if (b == 0) return 1;
    return (int'(b) + STEP_TB - 1) / STEP_TB + 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts one operation, scrambles the operand inputs while busy, and
  // waits (bounded) for done.
  task automatic run_op(input logic [31:0] a, input logic [4:0] b, input logic ar,
                        output logic [31:0] res, output int lat, output int busy_n,
                        output logic got_done);
    @(negedge clk);
    A = a; bits = b; arith = ar; start = 1'b1;
    res = '0; lat = 0; busy_n = 0; got_done = 1'b0;
    for (int c = 1; c <= 100 && !got_done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        A     = $urandom;
        bits  = 5'($urandom);
        arith = 1'($urandom);
      end
      if (busy) busy_n++;
      if (done) begin
        got_done = 1'b1;
        lat      = c;
        res      = A_shift;
      end
    end
  endtask

  task automatic apply(input string name, input logic [31:0] a, input logic [4:0] b,
                       input logic ar, input logic [31:0] exp);
    logic [31:0] res;
    int          lat, busy_n;
    logic        got;
    run_op(a, b, ar, res, lat, busy_n, got);
    check({name, "_done_seen"}, 64'(got), 64'(1));
    check({name, "_result"}, 64'(res), 64'(exp));
    check({name, "_latency"}, 64'(lat), 64'(ref_lat(b)));
    check({name, "_busy_cycles"}, 64'(busy_n), 64'(ref_lat(b)));
    @(negedge clk);
    check({name, "_done_single"}, 64'(done), 64'(0));
    check({name, "_idle_after"}, 64'(busy), 64'(0));
    check({name, "_result_held"}, 64'(A_shift), 64'(exp));
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] r;
    logic        exp_done;
    int          lat, bn, L, P, ndone;
    logic        got;

    vecs[0] = '{32'h80000010, 5'd4,  1'b0, 32'h08000001};
    vecs[1] = '{32'h80000010, 5'd4,  1'b1, 32'hF8000001};
    vecs[2] = '{32'h80000010, 5'd31, 1'b1, 32'hFFFFFFFF};
    vecs[3] = '{32'h12345678, 5'd0,  1'b0, 32'h12345678};
    vecs[4] = '{32'hFFFF0000, 5'd31, 1'b0, 32'h00000001};
    vecs[5] = '{32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000};
    vecs[6] = '{32'hFFFFFFFF, 5'd1,  1'b0, 32'h7FFFFFFF};
    vecs[7] = '{32'h80000000, 5'd16, 1'b1, 32'hFFFF8000};

    rst = 1'b1; start = 1'b0; A = '0; bits = '0; arith = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_ashift", 64'(A_shift), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ar, vecs[i].exp);

    // Abandon an operation with reset: no done may follow.
    @(negedge clk);
    A = 32'hFFFFFFFF; bits = 5'd20; arith = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rstmid_busy_pre", 64'(busy), 64'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", 64'(busy), 64'(0));
    check("rstmid_done", 64'(done), 64'(0));
    check("rstmid_ashift", 64'(A_shift), 64'(0));
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rstmid_no_done", 64'(ndone), 64'(0));

    // Start accepted in the first cycle after reset release.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b1; A = 32'h00000040; bits = 5'd2; arith = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_accept", 64'(busy), 64'(1));
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check("post_rst_done_seen", 64'(done), 64'(1));
    check("post_rst_result", 64'(A_shift), 64'(32'h00000010));
    @(negedge clk);

    // start held high with operands changing every cycle.
    L = ref_lat(5'd5);
    P = L + 1;
    ndone = 0;
    for (int t = 0; t < 4 * P; t++) begin
      @(negedge clk);
      if (t >= 1) begin
        exp_done = (t >= L) && (((t - L) % P) == 0);
        check("hold_done", 64'(done), 64'(exp_done));
        if (done) ndone++;
        if (exp_done && q.size() > 0) check("hold_result", 64'(A_shift), 64'(q.pop_front()));
      end
      start = 1'b1;
      A = $urandom;
      if (t % P == 0) begin
        bits  = 5'd5;
        arith = 1'((t / P) % 2);
        q.push_back(ref_shift(A, bits, arith));
      end else begin
        bits  = 5'($urandom);
        arith = 1'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("hold_done_count", 64'(ndone), 64'(4));
    @(negedge clk);
    check("hold_idle_after", 64'(busy), 64'(0));

    // Random sweep against the reference shift operators.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra;
      logic [4:0]  rb;
      logic        rar;
      ra  = $urandom;
      rb  = 5'($urandom_range(0, 31));
      rar = 1'($urandom);
      run_op(ra, rb, rar, r, lat, bn, got);
      check("rand_done_seen", 64'(got), 64'(1));
      check($sformatf("rand_result a=%0h b=%0d ar=%0d", ra, rb, rar), 64'(r), 64'(ref_shift(ra, rb, rar)));
      check("rand_latency", 64'(lat), 64'(ref_lat(rb)));
      @(negedge clk);
      check("rand_done_single", 64'(done), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
